// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetch queue entry: the instruction word together with its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifu_fetchq_if.sv
// Fetch unit boundary: ICCM read port, decode handshake and redirect inputs.
interface ifu_fetchq_if;

    logic [31:0] iccm_rd_addr;
    logic        iccm_rd_en;
    logic [31:0] iccm_rd_data;

    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    logic        flush_from_exe;
    logic [31:0] flush_addr_exe;
    logic        flush_from_dec;
    logic [31:0] flush_addr_dec;

    // The fetch unit itself.
    modport master (
        output iccm_rd_addr, iccm_rd_en,
        input  iccm_rd_data,
        output dec_valid, dec_pc, dec_instr,
        input  dec_ready,
        input  flush_from_exe, flush_addr_exe, flush_from_dec, flush_addr_dec
    );

    // ICCM, decode and execute as seen from the other side.
    modport slave (
        input  iccm_rd_addr, iccm_rd_en,
        output iccm_rd_data,
        input  dec_valid, dec_pc, dec_instr,
        output dec_ready,
        output flush_from_exe, flush_addr_exe, flush_from_dec, flush_addr_dec
    );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Circular fetch queue with push, pop, synchronous clear and occupancy.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_clear,
    output logic [CW-1:0] o_occ,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_occ;

    // Storage, pointers and occupancy; clear wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ <= r_occ + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifu_fetchq.sv
// Instruction fetch: sequential PC, credit-gated ICCM reads, in-flight
// tracking and a fetch queue draining to decode.
module ifu_fetchq
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 4,
    parameter int          ICCM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    ifu_fetchq_if.master   bus
);

    localparam int CW = ((FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1) + 1;
    localparam int SW = CW + 1;

    logic [31:0]   r_pc;
    logic          r_trk_vld_p [ICCM_LAT];
    logic [31:0]   r_trk_pc_p  [ICCM_LAT];

    logic          w_flush;
    logic [31:0]   w_target;
    logic          w_pop;
    logic          w_issue;
    logic [SW-1:0] w_inflight;
    logic [SW-1:0] w_credit;
    logic [CW-1:0] w_occ;
    logic          w_push;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Redirect selection: execute overrides decode, target forced to a word.
    always_comb begin
        w_flush  = bus.flush_from_exe | bus.flush_from_dec;
        w_target = word_align(bus.flush_from_exe ? bus.flush_addr_exe
                                                 : bus.flush_addr_dec);
    end

    // Credit check: queued plus in-flight words, minus the one leaving now,
    // must leave room so that every returning word finds a free slot.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ICCM_LAT; i++) begin
            w_inflight = w_inflight + SW'(r_trk_vld_p[i]);
        end
        w_pop    = bus.dec_valid & bus.dec_ready;
        w_credit = SW'(w_occ) + w_inflight - SW'(w_pop);
        w_issue  = rst_n & ~w_flush & (w_credit < SW'(FQ_DEPTH));
    end

    // PC register: redirect on flush, advance by one word on every issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_flush) begin
            r_pc <= w_target;
        end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // In-flight tracker: one stage per ICCM cycle; a flush kills every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ICCM_LAT; i++) begin
                r_trk_vld_p[i] <= 1'b0;
                r_trk_pc_p[i]  <= '0;
            end
        end else begin
            r_trk_vld_p[0] <= w_issue;
            r_trk_pc_p[0]  <= r_pc;
            for (int i = 1; i < ICCM_LAT; i++) begin
                r_trk_vld_p[i] <= r_trk_vld_p[i-1] & ~w_flush;
                r_trk_pc_p[i]  <= r_trk_pc_p[i-1];
            end
        end
    end

    // Returning word is queued unless a flush in this cycle makes it stale.
    always_comb begin
        w_push             = r_trk_vld_p[ICCM_LAT-1] & ~w_flush;
        w_push_entry.pc    = r_trk_pc_p[ICCM_LAT-1];
        w_push_entry.instr = bus.iccm_rd_data;
    end

    ifu_fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_clear      (w_flush),
        .o_occ        (w_occ),
        .o_head       (w_head)
    );

    // Outputs towards ICCM and decode.
    always_comb begin
        bus.iccm_rd_addr = r_pc;
        bus.iccm_rd_en   = w_issue;
        bus.dec_valid    = (w_occ != '0);
        bus.dec_pc       = w_head.pc;
        bus.dec_instr    = w_head.instr;
    end

endmodule
